// File: rtl/snn_pkg.sv
// Shared types, default sizes and width helpers for the spike-rate decoder.
package snn_pkg;

  localparam int unsigned NUM_CH_DEF  = 8;
  localparam int unsigned WIN_LEN_DEF = 16;
  localparam int unsigned CNT_W_DEF   = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dec_state_e;

  // Index/counter width for n distinct values, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_counter.sv
// Single-channel saturating spike accumulator with clear.
// SPIKE_DECODE_TTFS_EN adds first-spike time capture.
module spike_counter
  import snn_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
`ifdef SPIKE_DECODE_TTFS_EN
  , parameter int unsigned WIN_LEN = WIN_LEN_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             spk,
`ifdef SPIKE_DECODE_TTFS_EN
  input  logic [CNT_W-1:0] win_cnt,
  output logic [CNT_W-1:0] ttfs_c,
`endif
  output logic [CNT_W-1:0] sum_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] acc_q;

  // Count including this cycle's spike; the top latches this at window end.
  assign sum_c = (spk && (acc_q != CNT_MAX)) ? acc_q + CNT_W'(1) : acc_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc_q <= '0;
    end else if (inc) begin
      acc_q <= sum_c;
    end
  end

`ifdef SPIKE_DECODE_TTFS_EN
  localparam logic [CNT_W-1:0] NO_SPIKE = CNT_W'(WIN_LEN);

  logic [CNT_W-1:0] ttfs_q;

  // WIN_LEN doubles as the "no spike yet" marker; window counts never reach it.
  assign ttfs_c = ((ttfs_q == NO_SPIKE) && spk) ? win_cnt : ttfs_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ttfs_q <= NO_SPIKE;
    end else if (inc) begin
      ttfs_q <= ttfs_c;
    end
  end
`endif

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: per-channel counts plus arg-max on valid/ready.
// SPIKE_DECODE_TTFS_EN adds the time-to-first-spike output ttfs_out.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int unsigned NUM_CH  = NUM_CH_DEF,
  parameter int unsigned WIN_LEN = WIN_LEN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         spk_in,
  output logic [NUM_CH*CNT_W-1:0]   counts_out,
`ifdef SPIKE_DECODE_TTFS_EN
  output logic [NUM_CH*CNT_W-1:0]   ttfs_out,
`endif
  output logic [idx_w(NUM_CH)-1:0]  winner_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overrun
);

  localparam int unsigned      IDX_W   = idx_w(NUM_CH);
  localparam int unsigned      WC_W    = idx_w(WIN_LEN);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WIN_LEN - 1);

  dec_state_e               state_q;
  dec_state_e               state_d;
  logic [WC_W-1:0]          win_q;
  logic                     count_c;
  logic                     abort_c;
  logic                     win_end_c;
  logic [CNT_W-1:0]         sum_c [NUM_CH];
  logic [NUM_CH*CNT_W-1:0]  sum_flat_c;
  logic [CNT_W-1:0]         best_c;
  logic [IDX_W-1:0]         best_idx_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_c   = 1'b0;
    abort_c   = 1'b0;
    win_end_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = COUNT;
      end
      COUNT: begin
        if (en) begin
          count_c   = 1'b1;
          win_end_c = (win_q == WC_LAST);
        end else begin
          abort_c = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window position; wraps at window end so the next window starts without a gap.
  always_ff @(posedge clk) begin
    if (reset || !count_c || win_end_c) begin
      win_q <= '0;
    end else begin
      win_q <= win_q + WC_W'(1);
    end
  end

`ifdef SPIKE_DECODE_TTFS_EN
  logic [CNT_W-1:0]         ttfs_c [NUM_CH];
  logic [NUM_CH*CNT_W-1:0]  ttfs_flat_c;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    spike_counter #(
      .CNT_W   (CNT_W)
`ifdef SPIKE_DECODE_TTFS_EN
      , .WIN_LEN (WIN_LEN)
`endif
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (count_c),
      .clr     (abort_c | win_end_c),
      .spk     (spk_in[g]),
`ifdef SPIKE_DECODE_TTFS_EN
      .win_cnt (CNT_W'(win_q)),
      .ttfs_c  (ttfs_c[g]),
`endif
      .sum_c   (sum_c[g])
    );
  end

  // Arg-max; strict compare keeps the lowest index on ties.
  always_comb begin
    sum_flat_c = '0;
    best_c     = sum_c[0];
    best_idx_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum_flat_c[i*CNT_W +: CNT_W] = sum_c[i];
      if (sum_c[i] > best_c) begin
        best_c     = sum_c[i];
        best_idx_c = IDX_W'(i);
      end
    end
  end

`ifdef SPIKE_DECODE_TTFS_EN
  always_comb begin
    ttfs_flat_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ttfs_flat_c[i*CNT_W +: CNT_W] = ttfs_c[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ttfs_out <= '0;
    end else if (win_end_c) begin
      ttfs_out <= ttfs_flat_c;
    end
  end
`endif

  // Result register and handshake; a new result takes precedence over a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      counts_out <= '0;
      winner_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else if (win_end_c) begin
      counts_out <= sum_flat_c;
      winner_out <= best_idx_c;
      out_valid  <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: window table plus backpressure/abort/reset sequences.
module tb_spike_rate_decoder;

  localparam int unsigned NC = 8;
  localparam int unsigned WL = 16;
  localparam int unsigned CW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic [NC-1:0]  spk_in;
  logic [NC*CW-1:0] counts_out;
  logic [2:0]     winner_out;
  logic           out_valid;
  logic           out_ready;
  logic           overrun;
`ifdef SPIKE_DECODE_TTFS_EN
  logic [NC*CW-1:0] ttfs_out;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.NUM_CH(NC), .WIN_LEN(WL), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .spk_in     (spk_in),
    .counts_out (counts_out),
`ifdef SPIKE_DECODE_TTFS_EN
    .ttfs_out   (ttfs_out),
`endif
    .winner_out (winner_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun)
  );

  typedef struct {
    logic [7:0]  m1;
    int unsigned n1;
    logic [7:0]  m2;
    int unsigned n2;
    int unsigned exp_cnt [8];
    int unsigned exp_win;
    string       name;
  } win_vec_t;

  win_vec_t tv [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] cnt(input int ch);
    return counts_out[ch*CW +: CW];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    spk_in = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One 16-cycle window: m1 for n1 cycles, then m2 for n2 cycles, then silence.
  task automatic run_window(input logic [7:0] m1, input int unsigned n1,
                            input logic [7:0] m2, input int unsigned n2,
                            input logic exp_mid_valid);
    for (int unsigned c = 0; c < WL; c++) begin
      spk_in = (c < n1) ? m1 : ((c < n1 + n2) ? m2 : 8'h00);
      step();
      if (c == WL - 2) chk("mid_window_valid", 64'(out_valid), 64'(exp_mid_valid));
    end
    spk_in = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0] = '{8'h01, 16, 8'h00, 0, '{16, 0, 0, 0, 0, 0, 0, 0}, 0, "const_ch0"};
    tv[1] = '{8'h68, 2,  8'h28, 2, '{0, 0, 0, 4, 0, 4, 2, 0},  3, "tie_3_5"};
    tv[2] = '{8'h00, 0,  8'h00, 0, '{0, 0, 0, 0, 0, 0, 0, 0},  0, "silent"};
    tv[3] = '{8'hFF, 3,  8'h80, 13, '{3, 3, 3, 3, 3, 3, 3, 16}, 7, "ch7_wins"};
    tv[4] = '{8'h02, 5,  8'h04, 5, '{0, 5, 5, 0, 0, 0, 0, 0},  1, "tie_1_2"};
    tv[5] = '{8'hC0, 16, 8'h00, 0, '{0, 0, 0, 0, 0, 0, 16, 16}, 6, "tie_6_7_full"};

    out_ready = 1'b1;
    do_reset();
    chk("reset_valid",   64'(out_valid),  64'd0);
    chk("reset_counts",  64'(counts_out), 64'd0);
    chk("reset_winner",  64'(winner_out), 64'd0);
    chk("reset_overrun", 64'(overrun),    64'd0);

    // Back-to-back windows, consumer always ready.
    en = 1'b1;
    step();
    chk("idle_cycle_valid", 64'(out_valid), 64'd0);
    for (int t = 0; t < 6; t++) begin
      run_window(tv[t].m1, tv[t].n1, tv[t].m2, tv[t].n2, 1'b0);
      chk({tv[t].name, "_valid"}, 64'(out_valid), 64'd1);
      for (int ch = 0; ch < 8; ch++)
        chk($sformatf("%s_cnt%0d", tv[t].name, ch), 64'(cnt(ch)), 64'(tv[t].exp_cnt[ch]));
      chk({tv[t].name, "_winner"}, 64'(winner_out), 64'(tv[t].exp_win));
      chk({tv[t].name, "_overrun"}, 64'(overrun), 64'd0);
    end

    // Backpressure: second result overwrites the unaccepted first one.
    do_reset();
    out_ready = 1'b0;
    en = 1'b1;
    step();
    run_window(8'h02, 2, 8'h00, 0, 1'b0);
    chk("bp_w1_valid",   64'(out_valid), 64'd1);
    chk("bp_w1_cnt1",    64'(cnt(1)),    64'd2);
    chk("bp_w1_overrun", 64'(overrun),   64'd0);
    run_window(8'h10, 7, 8'h00, 0, 1'b1);
    chk("bp_w2_valid",   64'(out_valid),  64'd1);
    chk("bp_w2_cnt4",    64'(cnt(4)),     64'd7);
    chk("bp_w2_cnt1",    64'(cnt(1)),     64'd0);
    chk("bp_w2_winner",  64'(winner_out), 64'd4);
    chk("bp_w2_overrun", 64'(overrun),    64'd1);
    out_ready = 1'b1;
    spk_in = 8'h20;
    step();
    out_ready = 1'b0;
    chk("bp_accept_valid",   64'(out_valid), 64'd0);
    chk("bp_accept_overrun", 64'(overrun),   64'd1);
    repeat (WL - 1) step();
    chk("bp_w3_valid",   64'(out_valid),  64'd1);
    chk("bp_w3_cnt5",    64'(cnt(5)),     64'd16);
    chk("bp_w3_winner",  64'(winner_out), 64'd5);
    chk("bp_w3_overrun", 64'(overrun),    64'd1);

    // Reset mid-window while valid and overrun are set.
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("midrst_valid",   64'(out_valid),  64'd0);
    chk("midrst_overrun", 64'(overrun),    64'd0);
    chk("midrst_counts",  64'(counts_out), 64'd0);
    chk("midrst_winner",  64'(winner_out), 64'd0);
    reset = 1'b0;
    spk_in = '0;
    out_ready = 1'b1;
    repeat (WL) step();
    chk("midrst_idle_then_valid0", 64'(out_valid), 64'd0);
    step();
    chk("midrst_first_result", 64'(out_valid), 64'd1);

    // Abort at window cycle 7 after five ch2 spikes.
    do_reset();
    en = 1'b1;
    step();
    for (int c = 0; c < 7; c++) begin
      spk_in = (c < 5) ? 8'h04 : 8'h00;
      step();
    end
    en = 1'b0;
    spk_in = '0;
    step();
    chk("abort_valid", 64'(out_valid), 64'd0);
    en = 1'b1;
    step();
    repeat (WL - 1) step();
    chk("abort_no_early_valid", 64'(out_valid), 64'd0);
    step();
    chk("abort_next_valid",  64'(out_valid),  64'd1);
    chk("abort_next_counts", 64'(counts_out), 64'd0);
    chk("abort_next_winner", 64'(winner_out), 64'd0);

`ifdef SPIKE_DECODE_TTFS_EN
    // First-spike times: ch0 at 0, ch2 at 5 (again at 9), others silent.
    do_reset();
    en = 1'b1;
    step();
    chk("ttfs_reset", 64'(ttfs_out), 64'd0);
    for (int c = 0; c < 16; c++) begin
      spk_in = (c == 0) ? 8'h01 : ((c == 5 || c == 9) ? 8'h04 : 8'h00);
      step();
    end
    spk_in = '0;
    chk("ttfs_valid", 64'(out_valid), 64'd1);
    chk("ttfs_cnt2",  64'(cnt(2)),    64'd2);
    for (int ch = 0; ch < 8; ch++)
      chk($sformatf("ttfs_ch%0d", ch), 64'(ttfs_out[ch*CW +: CW]),
          (ch == 0) ? 64'd0 : ((ch == 2) ? 64'd5 : 64'd16));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
